tone_decoder: RTL and testbench

Receive-side counterpart to the piezo tune player. It monitors a square-wave tone line, measures the period between rising edges, and classifies each period against the shared note table (D7, E7, F7, A6). It emits one record per completed note: note code plus duration in clocks. It sits in the test/diagnostic path, listening to the piezo drive line so that tunes can be checked in hardware and in simulation.

---
 rtl/tone_pkg.sv | 48 ++++
 rtl/tone_classify.sv | 35 +++
 rtl/tone_decoder.sv | 235 +++++++++++++++++++++++
 tb/tb_tone_decoder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared definitions for the tone decoder (and the piezo tune player).
// Holds the note codes, the nominal tone periods in clk cycles at 50 MHz,
// the decoder state encoding, the reference tune and a saturating adder.
package tone_pkg;

  typedef enum logic [2:0] {
    NOTE_NONE = 3'd0,
    NOTE_D7   = 3'd1,
    NOTE_E7   = 3'd2,
    NOTE_F7   = 3'd3,
    NOTE_A6   = 3'd4
  } note_t;

  localparam int unsigned NOM_D7 = 21285;
  localparam int unsigned NOM_E7 = 18960;
  localparam int unsigned NOM_F7 = 17895;
  localparam int unsigned NOM_A6 = 28409;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_MEASURE = 2'd1;
  localparam state_t ST_LOCKED  = 2'd2;

  localparam int unsigned TUNE_LEN = 8;

  // Reference tune: D7 E7 F7 E7 F7 D7 A6 D7
  function automatic note_t tune_note(input logic [2:0] idx);
    note_t n;
    case (idx)
      3'd0:    n = NOTE_D7;
      3'd1:    n = NOTE_E7;
      3'd2:    n = NOTE_F7;
      3'd3:    n = NOTE_E7;
      3'd4:    n = NOTE_F7;
      3'd5:    n = NOTE_D7;
      3'd6:    n = NOTE_A6;
      default: n = NOTE_D7;
    endcase
    return n;
  endfunction

  function automatic logic [23:0] sat_add24(input logic [23:0] a, input logic [15:0] b);
    logic [24:0] s;
    s = {1'b0, a} + {9'd0, b};
    return s[24] ? 24'hFF_FFFF : s[23:0];
  endfunction

endpackage

// File: rtl/tone_classify.sv
// Purely combinational pitch classifier.
// Ports:
//   period_i  measured period in clocks
//   code_o    matching note code, NOTE_NONE when no nominal is within TOL
// Nominal periods default to the shared table and may be overridden.
module tone_classify
  import tone_pkg::*;
#(
  parameter int unsigned TOL       = 64,
  parameter int unsigned D7_PERIOD = tone_pkg::NOM_D7,
  parameter int unsigned E7_PERIOD = tone_pkg::NOM_E7,
  parameter int unsigned F7_PERIOD = tone_pkg::NOM_F7,
  parameter int unsigned A6_PERIOD = tone_pkg::NOM_A6
) (
  input  logic [15:0] period_i,
  output note_t       code_o
);

  function automatic logic near(input logic [15:0] p, input int unsigned nom);
    int unsigned pv;
    int unsigned diff;
    pv   = {16'd0, p};
    diff = (pv >= nom) ? (pv - nom) : (nom - pv);
    return diff <= TOL;
  endfunction

  always_comb begin
    code_o = NOTE_NONE;
    if (near(period_i, D7_PERIOD))      code_o = NOTE_D7;
    else if (near(period_i, E7_PERIOD)) code_o = NOTE_E7;
    else if (near(period_i, F7_PERIOD)) code_o = NOTE_F7;
    else if (near(period_i, A6_PERIOD)) code_o = NOTE_A6;
  end

endmodule

// File: rtl/tone_decoder.sv
// Tone line decoder: measures rising-edge periods of tone_in, classifies
// them against the note table and emits one record per completed note.
// Ports:
//   clk, rst_n   system clock, async active-low reset
//   tone_in      asynchronous square-wave tone line
//   note_vld     one-cycle record strobe
//   note_code    note of the record (held until the next record)
//   note_len     note duration in clocks (held until the next record)
//   active       high while a note is locked
//   seq_ok       pulses with the record completing the reference tune
// Optional feature macro: TONE_SEQ_CHECK_EN (tune sequence checker);
// without it seq_ok is tied low.
//
// state      | meaning
// ST_IDLE    | line silent, waiting for the first rising edge
// ST_MEASURE | collecting matching periods towards a lock
// ST_LOCKED  | note declared, accumulating its duration
module tone_decoder
  import tone_pkg::*;
#(
  parameter int unsigned TOL          = 64,
  parameter int unsigned LOCK_PERIODS = 2,
  parameter int unsigned TIMEOUT      = 32768,
  parameter int unsigned D7_PERIOD    = tone_pkg::NOM_D7,
  parameter int unsigned E7_PERIOD    = tone_pkg::NOM_E7,
  parameter int unsigned F7_PERIOD    = tone_pkg::NOM_F7,
  parameter int unsigned A6_PERIOD    = tone_pkg::NOM_A6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tone_in,
  output logic        note_vld,
  output logic [2:0]  note_code,
  output logic [23:0] note_len,
  output logic        active,
  output logic        seq_ok
);

  localparam logic [2:0] LOCK_N = LOCK_PERIODS[2:0];

  logic        sync1_q, sync2_q, sync3_q, rise_q;
  logic [15:0] per_q;
  state_t      state_q, state_d;
  note_t       cand_q, cand_d, cur_q, cur_d;
  logic [2:0]  mcnt_q, mcnt_d;
  logic [23:0] dur_q, dur_d;
  logic        vld_q, vld_d;
  logic [2:0]  code_q, code_d;
  logic [23:0] len_q, len_d;
  note_t       cls;
  logic        timeout;

  tone_classify #(
    .TOL       (TOL),
    .D7_PERIOD (D7_PERIOD),
    .E7_PERIOD (E7_PERIOD),
    .F7_PERIOD (F7_PERIOD),
    .A6_PERIOD (A6_PERIOD)
  ) u_classify (
    .period_i (per_q),
    .code_o   (cls)
  );

  // rise_q is registered so it appears 3 clocks after the pin edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      rise_q  <= 1'b0;
      per_q   <= 16'd0;
    end else begin
      sync1_q <= tone_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      rise_q  <= sync2_q & ~sync3_q;
      if (rise_q)                per_q <= 16'd1;
      else if (per_q != 16'hFFFF) per_q <= per_q + 16'd1;
    end
  end

  // per_q holds the measured period during the rise_q cycle
  assign timeout = ~rise_q & ({16'd0, per_q} >= TIMEOUT);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cur_d   = cur_q;
    mcnt_d  = mcnt_q;
    dur_d   = dur_q;
    vld_d   = 1'b0;
    code_d  = code_q;
    len_d   = len_q;
    case (state_q)
      ST_IDLE: begin
        if (rise_q) begin
          state_d = ST_MEASURE;
          cand_d  = NOTE_NONE;
          mcnt_d  = 3'd0;
          dur_d   = 24'd0;
        end
      end
      ST_MEASURE: begin
        if (rise_q) begin
          if (cls != NOTE_NONE && cls == cand_q) begin
            mcnt_d = mcnt_q + 3'd1;
            dur_d  = sat_add24(dur_q, per_q);
          end else if (cls != NOTE_NONE) begin
            cand_d = cls;
            mcnt_d = 3'd1;
            dur_d  = {8'd0, per_q};
          end else begin
            cand_d = NOTE_NONE;
            mcnt_d = 3'd0;
            dur_d  = 24'd0;
          end
          if (cls != NOTE_NONE && mcnt_d == LOCK_N) begin
            state_d = ST_LOCKED;
            cur_d   = cand_d;
          end
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (rise_q) begin
          if (cls == cur_q) begin
            dur_d = sat_add24(dur_q, per_q);
          end else begin
            vld_d  = 1'b1;
            code_d = cur_q;
            len_d  = dur_q;
            if (cls != NOTE_NONE) begin
              cand_d = cls;
              mcnt_d = 3'd1;
              dur_d  = {8'd0, per_q};
              if (LOCK_N == 3'd1) begin
                state_d = ST_LOCKED;
                cur_d   = cls;
              end else begin
                state_d = ST_MEASURE;
              end
            end else begin
              cand_d  = NOTE_NONE;
              mcnt_d  = 3'd0;
              dur_d   = 24'd0;
              state_d = ST_MEASURE;
            end
          end
        end else if (timeout) begin
          // trailing partial period is deliberately not added
          vld_d   = 1'b1;
          code_d  = cur_q;
          len_d   = dur_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cand_q  <= NOTE_NONE;
      cur_q   <= NOTE_NONE;
      mcnt_q  <= 3'd0;
      dur_q   <= 24'd0;
      vld_q   <= 1'b0;
      code_q  <= 3'd0;
      len_q   <= 24'd0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cur_q   <= cur_d;
      mcnt_q  <= mcnt_d;
      dur_q   <= dur_d;
      vld_q   <= vld_d;
      code_q  <= code_d;
      len_q   <= len_d;
    end
  end

  assign note_vld  = vld_q;
  assign note_code = code_q;
  assign note_len  = len_q;
  assign active    = (state_q == ST_LOCKED);

`ifdef TONE_SEQ_CHECK_EN
  logic [2:0]  seq_idx_q, seq_idx_d;
  logic        seq_ok_q, seq_ok_d;
  logic [17:0] idle_cnt_q;

  always_comb begin
    seq_idx_d = seq_idx_q;
    seq_ok_d  = 1'b0;
    if (vld_d) begin
      if (code_d == tune_note(seq_idx_q)) begin
        if (seq_idx_q == 3'(TUNE_LEN - 1)) begin
          seq_ok_d  = 1'b1;
          seq_idx_d = 3'd0;
        end else begin
          seq_idx_d = seq_idx_q + 3'd1;
        end
      end else begin
        // a mismatching D7 can itself be the start of a new tune
        seq_idx_d = (code_d == NOTE_D7) ? 3'd1 : 3'd0;
      end
    end else if ({14'd0, idle_cnt_q} > 2 * TIMEOUT) begin
      seq_idx_d = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_idx_q  <= 3'd0;
      seq_ok_q   <= 1'b0;
      idle_cnt_q <= 18'd0;
    end else begin
      seq_idx_q <= seq_idx_d;
      seq_ok_q  <= seq_ok_d;
      if (state_q == ST_IDLE && !rise_q) begin
        if (idle_cnt_q != 18'h3FFFF) idle_cnt_q <= idle_cnt_q + 18'd1;
      end else begin
        idle_cnt_q <= 18'd0;
      end
    end
  end

  assign seq_ok = seq_ok_q;
`else
  assign seq_ok = 1'b0;
`endif

endmodule

// File: tb/tb_tone_decoder.sv
module tb_tone_decoder;

  localparam int TOL     = 4;
  localparam int LOCK    = 2;
  localparam int TIMEOUT = 512;
  localparam int ND7 = 213, NE7 = 190, NF7 = 179, NA6 = 284;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tone_in;
  logic        note_vld;
  logic [2:0]  note_code;
  logic [23:0] note_len;
  logic        active;
  logic        seq_ok;

  always #5 clk = ~clk;

  tone_decoder #(
    .TOL(TOL), .LOCK_PERIODS(LOCK), .TIMEOUT(TIMEOUT),
    .D7_PERIOD(ND7), .E7_PERIOD(NE7), .F7_PERIOD(NF7), .A6_PERIOD(NA6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tone_in(tone_in), .note_vld(note_vld),
    .note_code(note_code), .note_len(note_len), .active(active), .seq_ok(seq_ok)
  );

  typedef struct {
    int code;
    int len;
    int seq;
  } rec_t;

  rec_t exp_q[$];
  rec_t e;
  int   checks = 0;
  int   failures = 0;
  bit   active_seen;
  int   last_code;
  int   seq_idx_m = 0;
  int   nom[5] = '{0, ND7, NE7, NF7, NA6};
  int   tune[8] = '{1, 2, 3, 2, 3, 1, 4, 1};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int classify_m(input int p);
    for (int k = 1; k <= 4; k++) begin
      int d;
      d = (p >= nom[k]) ? p - nom[k] : nom[k] - p;
      if (d <= TOL) return k;
    end
    return 0;
  endfunction

  function automatic int seq_step(input int code);
    int s;
    s = 0;
`ifdef TONE_SEQ_CHECK_EN
    if (code == tune[seq_idx_m]) begin
      if (seq_idx_m == 7) begin
        s = 1;
        seq_idx_m = 0;
      end else begin
        seq_idx_m++;
      end
    end else begin
      seq_idx_m = (code == 1) ? 1 : 0;
    end
`endif
    return s;
  endfunction

  // A note is a maximal run of periods sharing one non-zero class; it is
  // reported only if the run is at least LOCK periods long.
  task automatic push_expected(input int q[$], output int n_rec);
    int rk, rn, rs;
    rec_t r;
    rk = 0; rn = 0; rs = 0; n_rec = 0;
    for (int i = 0; i <= q.size(); i++) begin
      int k;
      k = (i < q.size()) ? classify_m(q[i]) : -1;
      if (k > 0 && k == rk) begin
        rn++;
        rs += q[i];
      end else begin
        if (rk != 0 && rn >= LOCK) begin
          r.code = rk;
          r.len  = rs;
          r.seq  = seq_step(rk);
          exp_q.push_back(r);
          n_rec++;
        end
        if (i < q.size()) begin
          rk = k;
          rn = (k != 0) ? 1 : 0;
          rs = q[i];
        end
      end
    end
  endtask

  task automatic drive_periods(input int q[$]);
    tone_in = 1'b1;
    foreach (q[i]) begin
      repeat (q[i] / 2) @(negedge clk);
      tone_in = 1'b0;
      repeat (q[i] - q[i] / 2) @(negedge clk);
      tone_in = 1'b1;
    end
  endtask

  task automatic run_burst(input string name, input int q[$]);
    int n_rec;
    active_seen = 1'b0;
    push_expected(q, n_rec);
    drive_periods(q);
    repeat (TIMEOUT + 40) @(negedge clk);
    tone_in = 1'b0;
    repeat (20) @(negedge clk);
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_active_seen"}, int'(active_seen), int'(n_rec > 0));
    check({name, "_active_end"}, int'(active), 0);
    if (n_rec > 0) check({name, "_code_hold"}, int'(note_code), last_code);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (active) active_seen = 1'b1;
      if (note_vld) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_record code=%0d len=%0d expected none", note_code, note_len);
        end else begin
          e = exp_q.pop_front();
          check("rec_code", int'(note_code), e.code);
          check("rec_len", int'(note_len), e.len);
          check("rec_seq_ok", int'(seq_ok), e.seq);
          last_code = e.code;
        end
      end else begin
        if (seq_ok) check("seq_ok_without_vld", 1, 0);
      end
    end
  end

  initial begin
    #(400_000 * 10);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];
    tone_in = 1'b0;
    rst_n   = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_vld", int'(note_vld), 0);
    check("rst_code", int'(note_code), 0);
    check("rst_len", int'(note_len), 0);
    check("rst_active", int'(active), 0);
    check("rst_seq_ok", int'(seq_ok), 0);
    rst_n = 1'b1;

    // idle line well past the timeout
    repeat (3 * TIMEOUT) @(negedge clk);
    check("idle_active", int'(active), 0);
    check("idle_code", int'(note_code), 0);

    q = {}; repeat (10) q.push_back(ND7 + 2);
    run_burst("d7_x10", q);

    q = {}; repeat (5) q.push_back(NE7 + 2); repeat (5) q.push_back(NF7 + 2);
    run_burst("e7_f7", q);

    q = '{250, 250, NA6 + 2, 250, 250};
    run_burst("lone_a6", q);

    q = {}; repeat (4) begin q.push_back(ND7 + TOL + 1); q.push_back(ND7); end
    run_burst("tol_out_hi", q);
    q = '{ND7 + TOL, ND7 + TOL, ND7};
    run_burst("tol_in_hi", q);
    q = '{ND7 - TOL, ND7 - TOL};
    run_burst("tol_in_lo", q);
    q = '{ND7 - TOL - 1, ND7, ND7 - TOL - 1};
    run_burst("tol_out_lo", q);

    q = {};
    foreach (tune[i]) repeat (3) q.push_back(nom[tune[i]]);
    run_burst("tune", q);

    for (int b = 0; b < 6; b++) begin
      q = {};
      repeat ($urandom_range(1, 3)) begin
        int k, n;
        k = $urandom_range(0, 4);
        n = $urandom_range(1, 4);
        repeat (n) begin
          if (k == 0) q.push_back($urandom_range(240, 270));
          else        q.push_back(nom[k] + $urandom_range(0, 2 * TOL) - TOL);
        end
      end
      run_burst("random", q);
    end

    // reset in the middle of a locked note: no record may follow
    q = {}; repeat (4) q.push_back(ND7);
    active_seen = 1'b0;
    drive_periods(q);
    repeat (100) @(negedge clk);
    check("pre_reset_active", int'(active), 1);
    rst_n = 1'b0;
    tone_in = 1'b0;
    seq_idx_m = 0;
    repeat (3) @(negedge clk);
    check("midrst_vld", int'(note_vld), 0);
    check("midrst_code", int'(note_code), 0);
    check("midrst_len", int'(note_len), 0);
    check("midrst_active", int'(active), 0);
    rst_n = 1'b1;
    repeat (TIMEOUT + 50) @(negedge clk);
    check("postrst_active", int'(active), 0);
    check("postrst_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
